// File: rtl/data_bus_pkg.sv
// ============================================================================
//  Module   : data_bus_pkg
//  Purpose  : Address map, decode enum and decode helper for data_bus_responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package data_bus_pkg;

    localparam logic [31:0] IO_BASE      = 32'h0000_1000;
    localparam logic [31:0] ADDR_LED     = IO_BASE + 32'h0;
    localparam logic [31:0] ADDR_SW      = IO_BASE + 32'h4;
    localparam logic [31:0] ADDR_COUNT   = IO_BASE + 32'h8;
    localparam logic [31:0] ADDR_COMPARE = IO_BASE + 32'hC;
    localparam logic [31:0] ADDR_STATUS  = IO_BASE + 32'h10;

    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_LED    = 3'd1,
        SEL_SW     = 3'd2,
        SEL_COUNT  = 3'd3,
        SEL_CMP    = 3'd4,
        SEL_STATUS = 3'd5,
        SEL_NONE   = 3'd6
    } bus_sel_t;

    // Byte-lane bits are dropped before matching, so 0x13 hits the word at 0x10.
    function automatic bus_sel_t bus_decode(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
        logic [31:0] w_word;
        bus_sel_t    w_sel;
        w_word = addr & ~32'h3;
        if (w_word < ram_bytes) begin
            w_sel = SEL_RAM;
        end else begin
            case (w_word)
                ADDR_LED:     w_sel = SEL_LED;
                ADDR_SW:      w_sel = SEL_SW;
                ADDR_COUNT:   w_sel = SEL_COUNT;
                ADDR_COMPARE: w_sel = SEL_CMP;
                ADDR_STATUS:  w_sel = SEL_STATUS;
                default:      w_sel = SEL_NONE;
            endcase
        end
        return w_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timer.sv
// ============================================================================
//  Module   : bus_timer
//  Purpose  : Prescaled COUNT register with COMPARE match and sticky flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_clr,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        flag_clr,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        flag
);

    localparam int unsigned       c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);

    logic [c_PS_W-1:0] pre_q, pre_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              flag_q, flag_d;

    logic w_tick;
    logic w_match;
    logic w_set;

    assign w_tick  = (pre_q == c_PS_LAST);
    // Match uses the COMPARE value held before any write in the same cycle.
    assign w_match = w_tick && (cmp_q != 32'd0) && (count_q == cmp_q);
    assign w_set   = w_match && !count_clr;

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        flag_d  = flag_q;

        if (count_clr) begin
            count_d = 32'd0;
            pre_d   = '0;
        end else if (w_tick) begin
            pre_d   = '0;
            count_d = w_match ? 32'd0 : count_q + 32'd1;
        end else begin
            pre_d   = pre_q + c_PS_ONE;
        end

        if (w_set) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end

        if (cmp_we) begin
            cmp_d = cmp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= 32'd0;
            cmp_q   <= 32'd0;
            flag_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
        end
    end

    assign count   = count_q;
    assign compare = cmp_q;
    assign flag    = flag_q;

endmodule

`default_nettype wire

// File: rtl/data_bus_responder.sv
// ============================================================================
//  Module   : data_bus_responder
//  Purpose  : Data-port responder: word RAM, LED/SW registers, timer, bus error.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned SW_W      = 8,
    parameter int unsigned LED_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      AddressDataMem,
    input  logic [31:0]      WriteDataMem,
    input  logic             WriteEnableMem,
    output logic [31:0]      ReadData,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             timer_irq,
    output logic             bus_err
);

    localparam int unsigned c_RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = 32'(RAM_WORDS * 4);

    bus_sel_t            w_sel;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_wr_ram;
    logic                w_wr_led;
    logic                w_wr_none;
    logic                w_count_clr;
    logic                w_cmp_we;
    logic                w_flag_clr;
    logic [31:0]         w_count;
    logic [31:0]         w_compare;
    logic                w_flag;

    logic [31:0]         mem [RAM_WORDS];
    logic [LED_W-1:0]    led_q, led_d;
    logic                err_q, err_d;
    logic [SW_W-1:0]     sw_meta_q;
    logic [SW_W-1:0]     sw_sync_q;

    assign w_sel     = bus_decode(AddressDataMem, c_RAM_BYTES);
    assign w_ram_idx = AddressDataMem[c_RAM_AW+1:2];

    assign w_wr_ram    = WriteEnableMem && (w_sel == SEL_RAM);
    assign w_wr_led    = WriteEnableMem && (w_sel == SEL_LED);
    assign w_wr_none   = WriteEnableMem && (w_sel == SEL_NONE);
    assign w_count_clr = WriteEnableMem && (w_sel == SEL_COUNT);
    assign w_cmp_we    = WriteEnableMem && (w_sel == SEL_CMP);
    assign w_flag_clr  = WriteEnableMem && (w_sel == SEL_STATUS) && WriteDataMem[0];

    // RAM has no reset, but a store coinciding with reset is still dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ram) begin
            mem[w_ram_idx] <= WriteDataMem;
        end
    end

    always_comb begin
        led_d = led_q;
        err_d = err_q;
        if (w_wr_led) begin
            led_d = WriteDataMem[LED_W-1:0];
        end
        if (w_wr_none) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            err_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            err_q     <= err_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    bus_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .count_clr (w_count_clr),
        .cmp_we    (w_cmp_we),
        .cmp_wdata (WriteDataMem),
        .flag_clr  (w_flag_clr),
        .count     (w_count),
        .compare   (w_compare),
        .flag      (w_flag)
    );

    // Loads never raise bus_err: the core drives junk addresses on non-memory ops.
    always_comb begin
        ReadData = 32'd0;
        case (w_sel)
            SEL_RAM:    ReadData = mem[w_ram_idx];
            SEL_LED:    ReadData[LED_W-1:0] = led_q;
            SEL_SW:     ReadData[SW_W-1:0]  = sw_sync_q;
            SEL_COUNT:  ReadData = w_count;
            SEL_CMP:    ReadData = w_compare;
            SEL_STATUS: ReadData[0] = w_flag;
            default:    ReadData = 32'd0;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = w_flag;
    assign bus_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// ============================================================================
//  Module   : tb_data_bus_responder
//  Purpose  : Directed plus randomized checks of data_bus_responder vs a model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_bus_responder;

    localparam int unsigned RAM_WORDS = 64;
    localparam int unsigned PRESCALE  = 1;
    localparam int unsigned SW_W      = 8;
    localparam int unsigned LED_W     = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      AddressDataMem;
    logic [31:0]      WriteDataMem;
    logic             WriteEnableMem;
    logic [31:0]      ReadData;
    logic [SW_W-1:0]  sw;
    logic [LED_W-1:0] led;
    logic             timer_irq;
    logic             bus_err;

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS (RAM_WORDS),
        .PRESCALE  (PRESCALE),
        .SW_W      (SW_W),
        .LED_W     (LED_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .AddressDataMem (AddressDataMem),
        .WriteDataMem   (WriteDataMem),
        .WriteEnableMem (WriteEnableMem),
        .ReadData       (ReadData),
        .sw             (sw),
        .led            (led),
        .timer_irq      (timer_irq),
        .bus_err        (bus_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Reference state, kept at the level of the memory map.
    logic [31:0]      m_ram [RAM_WORDS];
    logic [LED_W-1:0] m_led;
    logic [31:0]      m_cnt;
    logic [31:0]      m_cmp;
    int unsigned      m_pre;
    logic             m_flag;
    logic             m_err;
    logic [SW_W-1:0]  m_s1;
    logic [SW_W-1:0]  m_s2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w < RAM_WORDS * 4) return m_ram[w >> 2];
        case (w)
            32'h1000: return 32'(m_led);
            32'h1004: return 32'(m_s2);
            32'h1008: return m_cnt;
            32'h100C: return m_cmp;
            32'h1010: return {31'd0, m_flag};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led  = '0;
        m_cnt  = 32'd0;
        m_cmp  = 32'd0;
        m_pre  = 0;
        m_flag = 1'b0;
        m_err  = 1'b0;
        m_s1   = '0;
        m_s2   = '0;
    endtask

    task automatic model_update(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                                input logic we, input logic [SW_W-1:0] swv);
        logic [31:0] w;
        bit          tick;
        bit          hit;
        w = a & ~32'h3;
        if (rst) begin
            model_reset();
            return;
        end
        m_s2 = m_s1;
        m_s1 = swv;
        tick = (m_pre == PRESCALE - 1);
        hit  = tick && (m_cmp != 0) && (m_cnt == m_cmp);
        if (we && w == 32'h1008) begin
            m_cnt = 0;
            m_pre = 0;
            hit   = 0;
        end else begin
            m_pre = tick ? 0 : m_pre + 1;
            if (hit)       m_cnt = 0;
            else if (tick) m_cnt = m_cnt + 1;
        end
        if (hit) m_flag = 1'b1;
        else if (we && w == 32'h1010 && wd[0]) m_flag = 1'b0;
        if (we) begin
            if (w < RAM_WORDS * 4) begin
                m_ram[w >> 2] = wd;
            end else begin
                case (w)
                    32'h1000: m_led = wd[LED_W-1:0];
                    32'h1004, 32'h1008, 32'h1010: ;
                    32'h100C: m_cmp = wd;
                    default:  m_err = 1'b1;
                endcase
            end
        end
    endtask

    // One bus cycle: drive just after a rising edge, check mid-cycle, advance model.
    task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input bit lit_en, input logic [31:0] lit, input string tag);
        reset          = rst;
        AddressDataMem = a;
        WriteDataMem   = wd;
        WriteEnableMem = we;
        @(negedge clk);
        check_val({tag, "_model_rd"}, ReadData, model_read(a));
        if (lit_en) check_val(tag, ReadData, lit);
        check_val("led", 32'(led), 32'(m_led));
        check_val("irq", 32'(timer_irq), 32'(m_flag));
        check_val("err", 32'(bus_err), 32'(m_err));
        @(posedge clk);
        model_update(rst, a, wd, we, sw);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] lit, input string tag);
        cyc(1'b0, a, 32'd0, 1'b0, 1'b1, lit, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        cyc(1'b0, a, wd, 1'b1, 1'b0, 32'd0, "wr");
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic        rst;
        int unsigned r;

        sw             = '0;
        reset          = 1'b1;
        AddressDataMem = 32'h1000;
        WriteDataMem   = 32'd0;
        WriteEnableMem = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        cyc(1'b1, 32'h1000, 32'd0, 1'b0, 1'b1, 32'd0, "rst_led_rd");
        rd(32'h1008, 32'd0, "rst_count");
        rd(32'h1000, 32'd0, "rst_led");
        rd(32'h100C, 32'd0, "rst_cmp");
        rd(32'h1010, 32'd0, "rst_status");

        for (int i = 0; i < int'(RAM_WORDS); i++) wr(32'(i * 4), $urandom);

        // Store, read-during-write, byte-offset alias
        old_val = m_ram[4];
        cyc(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, old_val, "rdw_old");
        rd(32'h10, 32'hDEADBEEF, "ram_rd");
        rd(32'h13, 32'hDEADBEEF, "ram_rd_off3");

        // LED and switch synchronizer
        wr(32'h1000, 32'h1FF);
        check_val("led_ff", 32'(led), 32'hFF);
        rd(32'h1000, 32'h0000_00FF, "led_rd");
        sw = 8'hA5;
        rd(32'h1004, 32'd0, "sw_cyc1");
        rd(32'h1004, 32'd0, "sw_cyc2");
        rd(32'h1004, 32'hA5, "sw_cyc3");

        // Unmapped access
        rd(32'h2000, 32'd0, "unmapped_rd");
        check_val("err_after_rd", 32'(bus_err), 32'd0);
        wr(32'h2000, 32'h1234_5678);
        check_val("err_set", 32'(bus_err), 32'd1);
        rd(32'h0, m_ram[0], "ram0_intact");
        rd(32'h10, 32'hDEADBEEF, "ram10_intact");
        rd(32'h1000, 32'hFF, "led_intact");

        // Timer: COMPARE=5, COUNT cleared in a tick cycle
        wr(32'h100C, 32'd5);
        wr(32'h1008, 32'd0);
        for (int k = 0; k <= 10; k++) begin
            rd(32'h1008, 32'(k % 6), "count_seq");
            check_val("irq_seq", 32'(timer_irq), (k >= 5) ? 32'd1 : 32'd0);
        end
        wr(32'h1010, 32'd1);
        check_val("irq_set_beats_clr", 32'(timer_irq), 32'd1);
        wr(32'h1010, 32'd1);
        check_val("irq_cleared", 32'(timer_irq), 32'd0);
        check_val("err_sticky", 32'(bus_err), 32'd1);

        // Reset mid-operation with a pending LED write
        cyc(1'b1, 32'h1000, 32'h3C, 1'b1, 1'b0, 32'd0, "rst_mid");
        check_val("rst_mid_led", 32'(led), 32'd0);
        check_val("rst_mid_err", 32'(bus_err), 32'd0);
        check_val("rst_mid_irq", 32'(timer_irq), 32'd0);
        rd(32'h1008, 32'd0, "rst_mid_count");
        rd(32'h100C, 32'd0, "rst_mid_cmp");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      a = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
            else if (r < 90) a = 32'h1000 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            else if (r < 96) a = 32'h1014 + 32'($urandom_range(0, 64));
            else             a = $urandom;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            if ((a & ~32'h3) == 32'h100C) wd = 32'($urandom_range(0, 12));
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
            cyc(rst, a, wd, we, 1'b0, 32'd0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
